// File: rtl/div_rs.sv
// Reservation station for the integer divider: holds dispatched DIV/REM ops until both sources are ready.
// Latency: an op dispatched ready (or woken by the CDB) is issuable the cycle after the capturing edge.
// Backpressure: dis_ready drops when all entries are occupied; iss_ready=0 holds the oldest-eligible selection.

`ifndef ROB_LEN
`define ROB_LEN 16
`endif

module div_rs #(
   parameter int RS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dis_valid,
   output logic                         dis_ready,
   input  logic [2:0]                   dis_funct3,
   input  logic [6:0]                   dis_rs1_tag,
   input  logic [6:0]                   dis_rs2_tag,
   input  logic                         dis_rs1_rdy,
   input  logic                         dis_rs2_rdy,
   input  logic [31:0]                  dis_rs1_data,
   input  logic [31:0]                  dis_rs2_data,
   input  logic [$clog2(`ROB_LEN)-1:0]  dis_rob_idx,
   input  logic [6:0]                   dis_rd,
   input  logic                         cdb_valid,
   input  logic [6:0]                   cdb_tag,
   input  logic [31:0]                  cdb_data,
   input  logic                         mispredict,
   input  logic [`ROB_LEN-1:0]          flush_mask,
   output logic                         iss_valid,
   input  logic                         iss_ready,
   output logic [2:0]                   iss_funct3,
   output logic [31:0]                  iss_rs1_data,
   output logic [31:0]                  iss_rs2_data,
   output logic [$clog2(`ROB_LEN)-1:0]  iss_rob_idx,
   output logic [6:0]                   iss_rd,
   output logic [$clog2(RS_DEPTH):0]    rs_count
);

   localparam int RW = $clog2(`ROB_LEN);
   localparam int IW = $clog2(RS_DEPTH);
   localparam int CW = IW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RS_DEPTH);

   typedef struct packed {
      logic [6:0]  tag;
      logic        rdy;
      logic [31:0] data;
   } opnd_t;

   typedef struct packed {
      logic          vld;
      logic [2:0]    funct3;
      opnd_t         src1;
      opnd_t         src2;
      logic [RW-1:0] rob_idx;
      logic [6:0]    rd;
   } entry_t;

   entry_t              ent [RS_DEPTH];
   // older[i][j] = 1 when entry i was dispatched before entry j
   logic [RS_DEPTH-1:0] older [RS_DEPTH];

   logic [RS_DEPTH-1:0] flush_hit;
   logic [RS_DEPTH-1:0] elig;
   logic [RS_DEPTH-1:0] blk;
   logic [RS_DEPTH-1:0] sel_oh;
   logic [IW-1:0]       sel_idx;
   logic [IW-1:0]       free_idx;
   logic                dis_fire;
   logic                dis_kill;
   logic                dis_wr;
   logic                iss_fire;
   entry_t              new_ent;

   // Occupancy is the population count of the registered valid bits.
   always_comb begin
      rs_count = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         rs_count = rs_count + CW'(ent[i].vld);
      end
   end

   // Dispatch acceptance looks only at registered occupancy, so an issue this cycle never frees a slot early.
   assign dis_ready = (rs_count < DEPTH_C);
   assign dis_fire  = dis_valid & dis_ready;
   assign dis_kill  = mispredict & flush_mask[dis_rob_idx];
   assign dis_wr    = dis_fire & ~dis_kill;

   // Lowest-index free entry receives the next dispatch.
   always_comb begin
      free_idx = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (!ent[i].vld) free_idx = IW'(i);
      end
   end

   // Build the incoming entry, capturing a same-cycle CDB broadcast for any non-ready source.
   always_comb begin
      new_ent            = '0;
      new_ent.vld        = 1'b1;
      new_ent.funct3     = dis_funct3;
      new_ent.rob_idx    = dis_rob_idx;
      new_ent.rd         = dis_rd;
      new_ent.src1.tag   = dis_rs1_tag;
      new_ent.src1.rdy   = dis_rs1_rdy;
      new_ent.src1.data  = dis_rs1_data;
      new_ent.src2.tag   = dis_rs2_tag;
      new_ent.src2.rdy   = dis_rs2_rdy;
      new_ent.src2.data  = dis_rs2_data;
      if (!dis_rs1_rdy && cdb_valid && (cdb_tag == dis_rs1_tag)) begin
         new_ent.src1.rdy  = 1'b1;
         new_ent.src1.data = cdb_data;
      end
      if (!dis_rs2_rdy && cdb_valid && (cdb_tag == dis_rs2_tag)) begin
         new_ent.src2.rdy  = 1'b1;
         new_ent.src2.data = cdb_data;
      end
   end

   // An entry is eligible when valid, fully ready and not being killed by this cycle's flush.
   always_comb begin
      flush_hit = '0;
      elig      = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         flush_hit[i] = mispredict & ent[i].vld & flush_mask[ent[i].rob_idx];
         elig[i]      = ent[i].vld & ent[i].src1.rdy & ent[i].src2.rdy & ~flush_hit[i];
      end
   end

   // Oldest-eligible select: an entry is blocked if any other eligible entry is older than it.
   always_comb begin
      blk = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         for (int j = 0; j < RS_DEPTH; j++) begin
            if (j != i) blk[i] = blk[i] | (elig[j] & older[j][i]);
         end
      end
      sel_oh = elig & ~blk;
   end

   // Encode the one-hot selection into an entry index.
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (sel_oh[i]) sel_idx = IW'(i);
      end
   end

   assign iss_valid = |elig;
   assign iss_fire  = iss_valid & iss_ready;

   // Issue payload comes straight from the selected registered entry, zero when nothing is eligible.
   always_comb begin
      iss_funct3   = '0;
      iss_rs1_data = '0;
      iss_rs2_data = '0;
      iss_rob_idx  = '0;
      iss_rd       = '0;
      if (iss_valid) begin
         iss_funct3   = ent[sel_idx].funct3;
         iss_rs1_data = ent[sel_idx].src1.data;
         iss_rs2_data = ent[sel_idx].src2.data;
         iss_rob_idx  = ent[sel_idx].rob_idx;
         iss_rd       = ent[sel_idx].rd;
      end
   end

   // Entry state and age matrix: wakeup, issue/flush release, and dispatch allocation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            ent[i]   <= '0;
            older[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent[i].vld && !ent[i].src1.rdy && cdb_valid && (ent[i].src1.tag == cdb_tag)) begin
               ent[i].src1.rdy  <= 1'b1;
               ent[i].src1.data <= cdb_data;
            end
            if (ent[i].vld && !ent[i].src2.rdy && cdb_valid && (ent[i].src2.tag == cdb_tag)) begin
               ent[i].src2.rdy  <= 1'b1;
               ent[i].src2.data <= cdb_data;
            end
            if (flush_hit[i] || (iss_fire && sel_oh[i])) begin
               ent[i].vld <= 1'b0;
            end
         end
         // The free slot is never the issued or flushed one, so these writes cannot collide.
         if (dis_wr) begin
            ent[free_idx]   <= new_ent;
            older[free_idx] <= '0;
            for (int j = 0; j < RS_DEPTH; j++) begin
               if (IW'(j) != free_idx) older[j][free_idx] <= 1'b1;
            end
         end
      end
   end

endmodule
